cla_8bit: RTL and testbench

//   8-bit carry-lookahead adder for the 6502 datapath (ALU add/ADC path, address increment).

---
 rtl/cla_8bit_pkg.sv | 7 +
 rtl/cla_4bit.sv | 34 +++
 rtl/cla_8bit.sv | 87 ++++++++
 tb/tb_cla_8bit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cla_8bit_pkg.sv
// Shared ALU constants for the 6502 datapath adders.
package cla_8bit_pkg;

    localparam int unsigned WORD_W   = 8;
    localparam int unsigned NIBBLE_W = WORD_W / 2;

endpackage : cla_8bit_pkg

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead slice: sum bits plus group propagate/generate for cascading.
module cla_4bit
    import cla_8bit_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                Cin,
    output logic [NIBBLE_W-1:0] S,
    output logic                PG4,
    output logic                GG4
);

    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] c;

    // Bit-level propagate/generate, flat lookahead carries, sums and group terms.
    always_comb begin
        p = A ^ B;
        g = A & B;

        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);

        S   = p ^ c;
        PG4 = &p;
        GG4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule : cla_4bit

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder built from two 4-bit slices with a second lookahead level.
// REG_OUT selects a one-cycle registered output stage or a purely combinational path.
module cla_8bit
    import cla_8bit_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [WORD_W-1:0] S,
    output logic              Cout,
    output logic              PG,
    output logic              GG,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              Cin
);

    logic [NIBBLE_W-1:0] s_lo_c;
    logic [NIBBLE_W-1:0] s_hi_c;
    logic                pg_lo_c;
    logic                gg_lo_c;
    logic                pg_hi_c;
    logic                gg_hi_c;
    logic                c4_c;
    logic                pg_c;
    logic                gg_c;
    logic                cout_c;
    logic [WORD_W-1:0]   sum_c;

    cla_4bit u_lo (
        .A   (A[NIBBLE_W-1:0]),
        .B   (B[NIBBLE_W-1:0]),
        .Cin (Cin),
        .S   (s_lo_c),
        .PG4 (pg_lo_c),
        .GG4 (gg_lo_c)
    );

    cla_4bit u_hi (
        .A   (A[WORD_W-1:NIBBLE_W]),
        .B   (B[WORD_W-1:NIBBLE_W]),
        .Cin (c4_c),
        .S   (s_hi_c),
        .PG4 (pg_hi_c),
        .GG4 (gg_hi_c)
    );

    // Second-level lookahead: nibble carry, group terms and carry out, all from Cin directly.
    always_comb begin
        c4_c   = gg_lo_c | (pg_lo_c & Cin);
        pg_c   = pg_hi_c & pg_lo_c;
        gg_c   = gg_hi_c | (pg_hi_c & gg_lo_c);
        cout_c = gg_c | (pg_c & Cin);
        sum_c  = {s_hi_c, s_lo_c};
    end

    if (REG_OUT) begin : g_reg
        // Output register: capture every edge, synchronous clear while rst is high.
        always_ff @(posedge clk) begin
            if (rst) begin
                S    <= '0;
                Cout <= 1'b0;
                PG   <= 1'b0;
                GG   <= 1'b0;
            end else begin
                S    <= sum_c;
                Cout <= cout_c;
                PG   <= pg_c;
                GG   <= gg_c;
            end
        end
    end else begin : g_comb
        // Clock and reset have no role in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        // Zero-latency outputs straight from the lookahead network.
        always_comb begin
            S    = sum_c;
            Cout = cout_c;
            PG   = pg_c;
            GG   = gg_c;
        end
    end

endmodule : cla_8bit

// File: tb/tb_cla_8bit.sv
// Self-checking bench for cla_8bit: registered and combinational builds side by side.
`timescale 1ns/1ps
module tb_cla_8bit;

    typedef struct packed {
        logic       cout;
        logic       pg;
        logic       gg;
        logic [7:0] s;
    } res_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        res_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rrst;
    logic [7:0] ra, rb;
    logic       rcin;
    logic [7:0] rs;
    logic       rcout, rpg, rgg;

    logic       crst;
    logic [7:0] ca, cb;
    logic       ccin;
    logic [7:0] cs;
    logic       ccout, cpg, cgg;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    cla_8bit #(.REG_OUT(1'b1)) u_reg (
        .clk  (clk),
        .rst  (rrst),
        .S    (rs),
        .Cout (rcout),
        .PG   (rpg),
        .GG   (rgg),
        .A    (ra),
        .B    (rb),
        .Cin  (rcin)
    );

    cla_8bit #(.REG_OUT(1'b0)) u_comb (
        .clk  (clk),
        .rst  (crst),
        .S    (cs),
        .Cout (ccout),
        .PG   (cpg),
        .GG   (cgg),
        .A    (ca),
        .B    (cb),
        .Cin  (ccin)
    );

    // Reference: 9-bit arithmetic sum; GG is the carry out with Cin forced to 0.
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [8:0] sum;
        logic [8:0] gen;
        res_t       r;
        sum    = {1'b0, a} + {1'b0, b} + 9'(cin);
        gen    = {1'b0, a} + {1'b0, b};
        r.cout = sum[8];
        r.pg   = &(a ^ b);
        r.gg   = gen[8];
        r.s    = sum[7:0];
        return r;
    endfunction

    task automatic check(input string tag, input res_t obs, input res_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {cout,pg,gg,s}=%b_%b_%b_%h expected %b_%b_%b_%h",
                   tag, obs.cout, obs.pg, obs.gg, obs.s, exp.cout, exp.pg, exp.gg, exp.s);
        end
    endtask

    // Drive one registered operation; the expected result is queued and popped one edge later.
    task automatic reg_step(input string tag, input logic r, input logic [7:0] a,
                            input logic [7:0] b, input logic cin, input res_t exp);
        res_t got;
        res_t want;
        @(negedge clk);
        rrst = r;
        ra   = a;
        rb   = b;
        rcin = cin;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        got  = '{cout: rcout, pg: rpg, gg: rgg, s: rs};
        want = sb.pop_front();
        check(tag, got, want);
    endtask

    task automatic comb_step(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic cin, input res_t exp);
        res_t got;
        ca   = a;
        cb   = b;
        ccin = cin;
        #1;
        got = '{cout: ccout, pg: cpg, gg: cgg, s: cs};
        check(tag, got, exp);
    endtask

    vec_t dir[7];

    initial begin
        // Directed vectors with hand-derived expectations {cout,pg,gg,s}.
        dir[0] = '{a: 8'h00, b: 8'h77, cin: 1'b0, exp: '{1'b0, 1'b0, 1'b0, 8'h77}};
        dir[1] = '{a: 8'h00, b: 8'h77, cin: 1'b1, exp: '{1'b0, 1'b0, 1'b0, 8'h78}};
        dir[2] = '{a: 8'h94, b: 8'hF7, cin: 1'b0, exp: '{1'b1, 1'b0, 1'b1, 8'h8B}};
        dir[3] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, exp: '{1'b1, 1'b1, 1'b0, 8'h00}};
        dir[4] = '{a: 8'hFF, b: 8'h00, cin: 1'b0, exp: '{1'b0, 1'b1, 1'b0, 8'hFF}};
        dir[5] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp: '{1'b1, 1'b0, 1'b1, 8'h00}};
        dir[6] = '{a: 8'h80, b: 8'h80, cin: 1'b0, exp: '{1'b1, 1'b0, 1'b1, 8'h00}};

        rrst = 1'b1; ra = 8'h00; rb = 8'h00; rcin = 1'b0;
        crst = 1'b0; ca = 8'h00; cb = 8'h00; ccin = 1'b0;

        // Reset state with live inputs: outputs must clear.
        reg_step("reset_init", 1'b1, 8'h94, 8'hF7, 1'b1, '0);

        // Directed cases, registered build; first edge after release is already valid.
        foreach (dir[i])
            reg_step($sformatf("dir_reg%0d", i), 1'b0, dir[i].a, dir[i].b, dir[i].cin, dir[i].exp);

        // Mid-stream reset: nonzero outputs, one reset edge, then release with held inputs.
        reg_step("pre_rst", 1'b0, 8'hFF, 8'h00, 1'b1, '{1'b1, 1'b1, 1'b0, 8'h00});
        reg_step("pre_rst_nz", 1'b0, 8'h94, 8'hF7, 1'b0, '{1'b1, 1'b0, 1'b1, 8'h8B});
        reg_step("mid_rst", 1'b1, 8'h94, 8'hF7, 1'b0, '0);
        reg_step("post_rst", 1'b0, 8'h94, 8'hF7, 1'b0, '{1'b1, 1'b0, 1'b1, 8'h8B});

        // Back-to-back random traffic on the registered build.
        for (int k = 0; k < 300; k++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic       cin;
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            reg_step("rand_reg", 1'b0, a, b, cin, model(a, b, cin));
        end

        // Directed cases, combinational build.
        foreach (dir[i])
            comb_step($sformatf("dir_comb%0d", i), dir[i].a, dir[i].b, dir[i].cin, dir[i].exp);

        // Reset has no effect on the combinational build.
        crst = 1'b1;
        @(posedge clk);
        comb_step("comb_rst_ignored", 8'h94, 8'hF7, 1'b0, '{1'b1, 1'b0, 1'b1, 8'h8B});
        crst = 1'b0;

        // Exhaustive sweep of every A, B, Cin on the combinational build.
        for (int i = 0; i < 131072; i++) begin
            logic [16:0] v;
            v = 17'(i);
            comb_step("sweep", v[15:8], v[7:0], v[16], model(v[15:8], v[7:0], v[16]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cla_8bit
